// File: rtl/pkt_prior_arbiter_pkg.sv
// Shared types for the pkt_Priorer front-end arbiter.
// Header layout, state encoding and index-width helper.
package pkt_prior_arbiter_pkg;

  localparam int PKT_ARB_NPORT_MAX = 16;

  typedef struct packed {
    logic [7:0] key;
    logic [7:0] len;
  } pkHeadInfo;

  typedef enum logic {
    ARB_IDLE,
    ARB_SEND
  } pkt_arb_state_e;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_prior_arbiter_if.sv
// Requester-side and pkt_Priorer-side bundle of the arbiter.
// slave = arbiter view, master = requesters/sink view.
interface pkt_prior_arbiter_if
  import pkt_prior_arbiter_pkg::*;
#(
  parameter int NPORT  = 4,
  parameter int DWIDTH = 32
);
  localparam int IW = idx_w(NPORT);

  logic [NPORT-1:0]              req_valid;
  pkHeadInfo [NPORT-1:0]         req_info;
  logic [NPORT-1:0][DWIDTH-1:0]  req_data;
  logic [NPORT-1:0]              req_ready;
  logic                          pq_en;
  pkHeadInfo                     pq_info;
  logic [DWIDTH-1:0]             pq_data;
  logic [IW-1:0]                 pq_src;
  logic                          pq_rdy;
  logic                          busy;

  modport slave (
    input  req_valid, req_info, req_data, pq_rdy,
    output req_ready, pq_en, pq_info, pq_data,
    output pq_src, busy
  );

  modport master (
    output req_valid, req_info, req_data, pq_rdy,
    input  req_ready, pq_en, pq_info, pq_data,
    input  pq_src, busy
  );

endinterface

// File: rtl/pkt_prior_arbiter_rr_pick.sv
// Combinational rotating priority picker.
// First set request at/after ptr, wrapping at NPORT.
module pkt_rr_pick
  import pkt_prior_arbiter_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int IW    = idx_w(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [IW:0]   s;
  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    s   = '0;
    j   = '0;
    for (int i = 0; i < NPORT; i++) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      if (s >= (IW+1)'(NPORT))
        s = s - (IW+1)'(NPORT);
      j = s[IW-1:0];
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/pkt_prior_arbiter.sv
// N-port round-robin arbiter with burst cap feeding pkt_Priorer.
// One registered output beat, tagged with its source port.
module pkt_prior_arbiter
  import pkt_prior_arbiter_pkg::*;
#(
  parameter int NPORT     = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  pkt_prior_arbiter_if.slave bus
);

  localparam int IW = idx_w(NPORT);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BLAST = CW'(MAX_BURST - 1);

  pkt_arb_state_e    state, nstate;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     last_g;
  logic              have_last;
  logic [CW-1:0]     burst_cnt;

  pkHeadInfo         info_q;
  logic [DWIDTH-1:0] data_q;
  logic [IW-1:0]     src_q;

  logic [NPORT-1:0]  rr_gnt;
  logic [IW-1:0]     rr_idx;
  logic              rr_any;

  logic              load_ok;
  logic              stay;
  logic              load;
  logic [IW-1:0]     g;

  pkt_rr_pick #(
    .NPORT (NPORT),
    .IW    (IW)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // The current burst continues only while its owner keeps requesting
  always_comb begin
    load_ok = (state == ARB_IDLE) ||
              (state == ARB_SEND && bus.pq_rdy);
    stay    = have_last && bus.req_valid[last_g] &&
              (burst_cnt < BLAST);
    g       = stay ? last_g : rr_idx;
    load    = load_ok && rr_any && rst;
    nstate  = state;
    if (load_ok)
      nstate = rr_any ? ARB_SEND : ARB_IDLE;
    bus.req_ready = '0;
    if (load)
      bus.req_ready = stay ? (NPORT'(1) << last_g) : rr_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      info_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
      rr_ptr    <= '0;
      last_g    <= '0;
      have_last <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state <= nstate;
      if (load) begin
        info_q    <= bus.req_info[g];
        data_q    <= bus.req_data[g];
        src_q     <= g;
        last_g    <= g;
        have_last <= 1'b1;
        if (stay) begin
          burst_cnt <= burst_cnt + CW'(1);
        end else begin
          burst_cnt <= '0;
          rr_ptr    <= (g == IW'(NPORT - 1)) ? '0 : g + IW'(1);
        end
      end
    end
  end

  assign bus.pq_en   = (state == ARB_SEND);
  assign bus.pq_info = info_q;
  assign bus.pq_data = data_q;
  assign bus.pq_src  = src_q;
  assign bus.busy    = bus.pq_en | (|bus.req_valid);

endmodule

// File: tb/tb_pkt_prior_arbiter.sv
// Scoreboard bench for pkt_prior_arbiter.
// Per-port expected FIFOs filled on accept, drained on pq_en & pq_rdy.
module tb_pkt_prior_arbiter;
  import pkt_prior_arbiter_pkg::*;

  typedef struct packed {
    pkHeadInfo   info;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  pkt_prior_arbiter_if #(.NPORT(4), .DWIDTH(32)) bus ();
  pkt_prior_arbiter_if #(.NPORT(4), .DWIDTH(32)) rr_bus ();

  pkt_prior_arbiter #(
    .NPORT(4), .DWIDTH(32), .MAX_BURST(4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pkt_prior_arbiter #(
    .NPORT(4), .DWIDTH(32), .MAX_BURST(1)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_bus)
  );

  beat_t src_q [4][$];
  beat_t exp_q [4][$];
  int    out_log [$];
  logic [3:0] accepted;
  logic [3:0] last_ready;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_out  = 0;
  int    tid    = 0;

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(int p, int k);
    beat_t b;
    b.info.key = 8'(k);
    b.info.len = 8'(p);
    b.data     = {8'(p), 8'(tid), 16'(k)};
    return b;
  endfunction

  task automatic sample();
    beat_t b;
    int s;
    last_ready = bus.req_ready;
    check("onehot", 64'($countones(bus.req_ready) <= 1), 1);
    check("ready_no_valid",
          64'(bus.req_ready & ~bus.req_valid), 0);
    if (bus.pq_en && bus.pq_rdy) begin
      s = int'(bus.pq_src);
      out_log.push_back(s);
      n_out++;
      if (exp_q[s].size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        b = exp_q[s].pop_front();
        check("data", 64'(bus.pq_data), 64'(b.data));
        check("info", 64'(bus.pq_info), 64'(b.info));
      end
    end
    for (int p = 0; p < 4; p++) begin
      accepted[p] = bus.req_valid[p] & bus.req_ready[p];
      if (accepted[p])
        exp_q[p].push_back(src_q[p][0]);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      if (accepted[p]) begin
        void'(src_q[p].pop_front());
        accepted[p] = 1'b0;
      end
      bus.req_valid[p] = (src_q[p].size() != 0);
      bus.req_info[p]  = bus.req_valid[p] ? src_q[p][0].info : '0;
      bus.req_data[p]  = bus.req_valid[p] ? src_q[p][0].data : '0;
    end
    bus.pq_rdy = rdy;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic flush_exp();
    for (int p = 0; p < 4; p++) exp_q[p].delete();
    accepted = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_exp();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    out_log.delete();
    n_out = 0;
    drive();
  endtask

  task automatic drain(int budget);
    int i = 0;
    bit pend = 1'b1;
    while (pend && i < budget) begin
      cycle();
      i++;
      pend = bus.pq_en;
      for (int p = 0; p < 4; p++)
        if (src_q[p].size() != 0 || exp_q[p].size() != 0)
          pend = 1'b1;
    end
    check("drain_done", 64'(pend), 0);
    check("busy_idle", 64'(bus.busy), 0);
  endtask

  task automatic chk_log(string tag, input int e[$]);
    check(tag, 64'(out_log.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < out_log.size(); i++)
      check(tag, 64'(out_log[i]), 64'(e[i]));
  endtask

  initial begin
    pkHeadInfo hd_info;
    logic [31:0] hd_data;
    logic [1:0] hd_src;
    bit seen;
    int k;
    int e[$];
    accepted = '0;
    last_ready = '0;
    rr_bus.req_valid = 4'hF;
    rr_bus.pq_rdy = 1'b1;
    for (int p = 0; p < 4; p++) begin
      rr_bus.req_info[p] = '0;
      rr_bus.req_data[p] = 32'(p);
    end
    drive();

    // Reset holds everything quiet while all ports request
    tid = 1;
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 2; j++) src_q[p].push_back(mk(p, j));
    drive();
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 0);
    check("rst_pq_en", 64'(bus.pq_en), 0);
    check("rst_pq_data", 64'(bus.pq_data), 0);
    check("rst_pq_src", 64'(bus.pq_src), 0);
    check("rst_busy", 64'(bus.busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive();
    cycle();
    check("first_grant", 64'(last_ready), 64'(4'b0001));
    check("first_en", 64'(bus.pq_en), 1);
    check("first_src", 64'(bus.pq_src), 0);
    drain(100);
    e = '{0, 0, 1, 1, 2, 2, 3, 3};
    chk_log("t1_order", e);

    // Pure round robin, one beat every cycle
    tid = 2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_en", 64'(rr_bus.pq_en), 1);
      check("rr_src", 64'(rr_bus.pq_src), 64'(i % 4));
      check("rr_data", 64'(rr_bus.pq_data), 64'(i % 4));
    end

    // Burst cap of four between ports 1 and 2
    tid = 3;
    for (int j = 0; j < 8; j++) src_q[1].push_back(mk(1, j));
    for (int j = 0; j < 4; j++) src_q[2].push_back(mk(2, j));
    do_reset();
    drain(100);
    e = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
    chk_log("t3_order", e);

    // Backpressure mid-stream
    tid = 4;
    for (int j = 0; j < 5; j++) src_q[1].push_back(mk(1, j));
    for (int j = 0; j < 5; j++) src_q[3].push_back(mk(3, j));
    do_reset();
    repeat (3) cycle();
    rdy = 1'b0;
    drive();
    hd_info = bus.pq_info;
    hd_data = bus.pq_data;
    hd_src  = bus.pq_src;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_ready", 64'(last_ready), 0);
      check("bp_en", 64'(bus.pq_en), 1);
      check("bp_data", 64'(bus.pq_data), 64'(hd_data));
      check("bp_info", 64'(bus.pq_info), 64'(hd_info));
      check("bp_src", 64'(bus.pq_src), 64'(hd_src));
    end
    rdy = 1'b1;
    drive();
    drain(100);
    check("bp_count", 64'(n_out), 10);

    // Sparse: port 3 alone, then port 0 joins
    tid = 5;
    for (int j = 16; j <= 22; j++) src_q[3].push_back(mk(3, j));
    do_reset();
    repeat (2) cycle();
    src_q[0].push_back(mk(0, 99));
    drive();
    drain(100);
    e = '{3, 3, 3, 3, 0, 3, 3, 3};
    chk_log("t5_order", e);

    // Async reset while a beat is stalled on the output
    tid = 6;
    for (int j = 0; j < 4; j++) src_q[2].push_back(mk(2, j));
    do_reset();
    rdy = 1'b0;
    drive();
    seen = 1'b0;
    k = 0;
    while (!seen && k < 10) begin
      cycle();
      seen = bus.pq_en;
      k++;
    end
    check("t6_loaded", 64'(seen), 1);
    rst = 1'b0;
    #1;
    check("t6_en_drop", 64'(bus.pq_en), 0);
    check("t6_ready", 64'(bus.req_ready), 0);
    flush_exp();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rdy = 1'b1;
    out_log.delete();
    n_out = 0;
    drive();
    drain(100);
    check("t6_count", 64'(n_out), 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
